// File: rtl/box_stats_window.sv
// box_stats_window: WIN x WIN sliding-window sum, sum of squares and mean over a raster pixel stream.
// Ports: clk, rst (async active-low); in_valid/in_pixel/in_sof pixel beats; out_valid/out_sum/out_sqsum/
//   out_mean/out_eof window results (3 cycles after the accepting edge); err_sof sticky SOF-misalignment flag.
// No backpressure: bubbles pass through unchanged. Macro BOX_STATS_SQSUM_EN builds the sum-of-squares path.
module box_stats_window #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int WIN    = 7,
  localparam int SUM_W = DATA_W + $clog2(WIN * WIN),
  localparam int SQ_W  = 2 * DATA_W + $clog2(WIN * WIN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_pixel,
  input  logic              in_sof,
  output logic              out_valid,
  output logic [SUM_W-1:0]  out_sum,
  output logic [SQ_W-1:0]   out_sqsum,
  output logic [DATA_W-1:0] out_mean,
  output logic              out_eof,
  output logic              err_sof
);

  localparam int XW    = $clog2(IMG_W);
  localparam int YW    = $clog2(IMG_H);
  localparam int LINES = WIN - 1;
  localparam int RECIP = (65536 + WIN * WIN - 1) / (WIN * WIN);
  localparam int MUL_W = SUM_W + 17;

  // ---------------------------------------------------------------- position tracking
  logic [XW-1:0] x_q, x_d, xe;
  logic [YW-1:0] y_q, y_d, ye;
  logic          err_q;

  // An SOF beat is always placed at (0,0); counters continue from there.
  always_comb begin
    xe  = in_sof ? '0 : x_q;
    ye  = in_sof ? '0 : y_q;
    x_d = xe + XW'(1);
    y_d = ye;
    if (xe == XW'(IMG_W - 1)) begin
      x_d = '0;
      y_d = (ye == YW'(IMG_H - 1)) ? '0 : ye + YW'(1);
    end
  end

  // ---------------------------------------------------------------- line buffers
  // lb_q[0] holds line y-1, lb_q[k] holds line y-1-k at the same column.
  // Never cleared: a window only qualifies once WIN-1 lines of this frame are stored.
  logic [DATA_W-1:0] lb_q [LINES][IMG_W];

  always_ff @(posedge clk) begin
    if (in_valid) begin
      lb_q[0][xe] <= in_pixel;
      for (int k = 1; k < LINES; k++) begin
        lb_q[k][xe] <= lb_q[k-1][xe];
      end
    end
  end

  // ---------------------------------------------------------------- S1: column sums
  logic [SUM_W-1:0] col_sum_c;
  always_comb begin
    col_sum_c = SUM_W'(in_pixel);
    for (int k = 0; k < LINES; k++) begin
      col_sum_c = col_sum_c + SUM_W'(lb_q[k][xe]);
    end
  end

  logic             v1_q, win1_q, eof1_q;
  logic [SUM_W-1:0] col_sum_q;

  // S2 is split into a column shift register (v2) and the window add (v3).
  logic             v2_q, eof2_q, v3_q, eof3_q;
  logic [SUM_W-1:0] colsr_q [WIN];
  logic [SUM_W-1:0] win_sum_q, win_sum_c;

  logic              out_valid_q, out_eof_q;
  logic [SUM_W-1:0]  out_sum_q;
  logic [DATA_W-1:0] out_mean_q;

  always_comb begin
    win_sum_c = '0;
    for (int j = 0; j < WIN; j++) begin
      win_sum_c = win_sum_c + colsr_q[j];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q         <= '0;
      y_q         <= '0;
      err_q       <= 1'b0;
      v1_q        <= 1'b0;
      win1_q      <= 1'b0;
      eof1_q      <= 1'b0;
      col_sum_q   <= '0;
      v2_q        <= 1'b0;
      eof2_q      <= 1'b0;
      v3_q        <= 1'b0;
      eof3_q      <= 1'b0;
      win_sum_q   <= '0;
      out_valid_q <= 1'b0;
      out_eof_q   <= 1'b0;
      out_sum_q   <= '0;
      out_mean_q  <= '0;
    end else begin
      // S1
      v1_q   <= in_valid;
      win1_q <= (xe >= XW'(WIN - 1)) && (ye >= YW'(WIN - 1));
      eof1_q <= (xe == XW'(IMG_W - 1)) && (ye == YW'(IMG_H - 1));
      if (in_valid) begin
        col_sum_q <= col_sum_c;
        x_q       <= x_d;
        y_q       <= y_d;
        if (in_sof && (x_q != '0 || y_q != '0)) begin
          err_q <= 1'b1;
        end
      end
      // S2a: shift register advances on beats only, so bubbles do not disturb the window
      v2_q   <= v1_q && win1_q;
      eof2_q <= v1_q && win1_q && eof1_q;
      // S2b
      v3_q   <= v2_q;
      eof3_q <= eof2_q;
      if (v2_q) begin
        win_sum_q <= win_sum_c;
      end
      // S3: data held between pulses
      out_valid_q <= v3_q;
      out_eof_q   <= eof3_q;
      if (v3_q) begin
        out_sum_q  <= win_sum_q;
        out_mean_q <= DATA_W'((MUL_W'(win_sum_q) * MUL_W'(RECIP)) >> 16);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (v1_q) begin
      colsr_q[0] <= col_sum_q;
      for (int j = 1; j < WIN; j++) begin
        colsr_q[j] <= colsr_q[j-1];
      end
    end
  end

  // ---------------------------------------------------------------- sum of squares
`ifdef BOX_STATS_SQSUM_EN
  logic [SQ_W-1:0] col_sq_c, col_sq_q, win_sq_c, win_sq_q, out_sq_q;
  logic [SQ_W-1:0] sqsr_q [WIN];

  always_comb begin
    col_sq_c = SQ_W'(in_pixel) * SQ_W'(in_pixel);
    for (int k = 0; k < LINES; k++) begin
      col_sq_c = col_sq_c + SQ_W'(lb_q[k][xe]) * SQ_W'(lb_q[k][xe]);
    end
    win_sq_c = '0;
    for (int j = 0; j < WIN; j++) begin
      win_sq_c = win_sq_c + sqsr_q[j];
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid) begin
      col_sq_q <= col_sq_c;
    end
    if (v1_q) begin
      sqsr_q[0] <= col_sq_q;
      for (int j = 1; j < WIN; j++) begin
        sqsr_q[j] <= sqsr_q[j-1];
      end
    end
    if (v2_q) begin
      win_sq_q <= win_sq_c;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_sq_q <= '0;
    end else if (v3_q) begin
      out_sq_q <= win_sq_q;
    end
  end

  assign out_sqsum = out_sq_q;
`else
  assign out_sqsum = '0;
`endif

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_mean  = out_mean_q;
  assign out_eof   = out_eof_q;
  assign err_sof   = err_q;

endmodule

// File: tb/tb_box_stats_window.sv
module tb_box_stats_window;
  localparam int DW = 8, IW = 16, IH = 12, WN = 7;
  localparam int SUM_W = 14, SQ_W = 22;
`ifdef BOX_STATS_SQSUM_EN
  localparam int SQ_ON = 1;
`else
  localparam int SQ_ON = 0;
`endif

  logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0, in_sof = 1'b0;
  logic [DW-1:0] in_pixel = '0;
  logic out_valid, out_eof, err_sof;
  logic [SUM_W-1:0] out_sum;
  logic [SQ_W-1:0] out_sqsum;
  logic [DW-1:0] out_mean;

  box_stats_window #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH), .WIN(WN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_pixel(in_pixel), .in_sof(in_sof),
    .out_valid(out_valid), .out_sum(out_sum), .out_sqsum(out_sqsum), .out_mean(out_mean),
    .out_eof(out_eof), .err_sof(err_sof)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int sum; int sq; int mean; int eof; int cyc; } res_t;
  typedef struct { int pat; int val; int bub; int f_sum; int f_mean; int f_sq; int l_sum; int l_mean; int l_sq; } vec_t;

  res_t exp_q[$];
  vec_t tbl[4];
  int total = 0, bad = 0;
  int n_res, f_sum, f_mean, f_sq, l_sum, l_mean, l_sq;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d (t=%0t)", nm, got, want, $time);
    end
  endtask

  function automatic int pix_of(input int pat, input int val, input int x);
    return (pat == 0) ? val : x;
  endfunction

  // Reference result for the window whose bottom-right corner is column x.
  function automatic res_t model(input int pat, input int val, input int x, input int y, input int c);
    res_t r;
    int s = 0, q = 0;
    for (int i = x - 6; i <= x; i++) begin
      s += 7 * pix_of(pat, val, i);
      q += 7 * pix_of(pat, val, i) * pix_of(pat, val, i);
    end
    r.sum = s;
    r.sq = q * SQ_ON;
    r.mean = (s * 1338) >> 16;
    r.eof = (x == IW - 1 && y == IH - 1) ? 1 : 0;
    r.cyc = c;
    return r;
  endfunction

  task automatic send(input int pat, input int val, input int bub, input bit sof, input int x, input int y);
    if (bub != 0) begin
      while ($urandom_range(0, 99) >= 40) begin
        @(posedge clk); #1;
        in_valid = 1'b0; in_sof = 1'b0;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_sof = sof;
    in_pixel = DW'(pix_of(pat, val, x));
    // accepted at the next edge (cyc+1), visible 3 edges later
    if (x >= WN - 1 && y >= WN - 1) exp_q.push_back(model(pat, val, x, y, cyc + 4));
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
    chk("drain_pending", 32'(exp_q.size()), 0);
  endtask

  task automatic run_frame(input int pat, input int val, input int bub);
    for (int y = 0; y < IH; y++)
      for (int x = 0; x < IW; x++)
        send(pat, val, bub, (x == 0 && y == 0), x, y);
    idle();
    drain();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk({tag, "_sum"}, 32'(out_sum), 0);
    chk({tag, "_sqsum"}, 32'(out_sqsum), 0);
    chk({tag, "_mean"}, 32'(out_mean), 0);
    chk({tag, "_eof"}, 32'(out_eof), 0);
    chk({tag, "_err"}, 32'(err_sof), 0);
  endtask

  initial begin
    //           pat val bub f_sum f_mean f_sq     l_sum  l_mean l_sq
    tbl[0] = '{0, 100, 0, 4900,  100, 490000,  4900,  100, 490000};
    tbl[1] = '{0, 255, 0, 12495, 255, 3186225, 12495, 255, 3186225};
    tbl[2] = '{1, 0,   0, 147,   3,   637,     588,   12,  7252};
    tbl[3] = '{1, 0,   1, 147,   3,   637,     588,   12,  7252};

    fork
      forever begin
        @(negedge clk);
        if (out_valid) begin
          res_t e;
          n_res++;
          if (exp_q.size() == 0) begin
            chk("unexpected_pulse", 32'(out_sum), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("sum", 32'(out_sum), e.sum);
            chk("sqsum", 32'(out_sqsum), e.sq);
            chk("mean", 32'(out_mean), e.mean);
            chk("eof", 32'(out_eof), e.eof);
            chk("latency_cyc", cyc, e.cyc);
          end
          if (n_res == 1) begin
            f_sum = int'(out_sum); f_mean = int'(out_mean); f_sq = int'(out_sqsum);
          end
          l_sum = int'(out_sum); l_mean = int'(out_mean); l_sq = int'(out_sqsum);
        end else begin
          chk("eof_without_valid", 32'(out_eof), 0);
        end
      end
    join_none

    // reset values
    #12;
    chk_zero("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    // table of whole-frame scenarios
    for (int t = 0; t < 4; t++) begin
      n_res = 0;
      run_frame(tbl[t].pat, tbl[t].val, tbl[t].bub);
      chk("frame_count", n_res, 60);
      chk("first_sum", f_sum, tbl[t].f_sum);
      chk("first_mean", f_mean, tbl[t].f_mean);
      chk("first_sq", f_sq, tbl[t].f_sq * SQ_ON);
      chk("last_sum", l_sum, tbl[t].l_sum);
      chk("last_mean", l_mean, tbl[t].l_mean);
      chk("last_sq", l_sq, tbl[t].l_sq * SQ_ON);
      chk("err_sof_clean", 32'(err_sof), 0);
    end

    // SOF misaligned at (5,3), then a full frame
    n_res = 0;
    for (int y = 0; y <= 3; y++)
      for (int x = 0; x < IW; x++)
        if (!(y == 3 && x >= 5)) send(1, 0, 0, (x == 0 && y == 0), x, y);
    chk("err_before_inject", 32'(err_sof), 0);
    run_frame(0, 100, 0);
    chk("err_sof_set", 32'(err_sof), 1);
    chk("inject_count", n_res, 60);
    run_frame(1, 0, 1);
    chk("err_sof_sticky", 32'(err_sof), 1);

    // reset mid-frame at (8,9)
    for (int y = 0; y <= 9; y++)
      for (int x = 0; x < IW; x++)
        if (!(y == 9 && x >= 8)) send(1, 0, 0, (x == 0 && y == 0), x, y);
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0; in_sof = 1'b0;
    exp_q.delete();
    #1;
    chk_zero("midreset");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    n_res = 0;
    run_frame(0, 255, 0);
    chk("post_reset_count", n_res, 60);
    chk("post_reset_first", f_sum, 12495);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule
